// File: rtl/fsm_share_sched.sv
// fsm_share_sched: one shared S0..S3 sequence-recognizer step time-multiplexed
// round-robin across NCH symbol streams. Optional hit counters: FSM_SHARE_HITCNT_EN.
module fsm_share_sched #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   in_valid,
  input  logic [2*NCH-1:0] in_ab,
  output logic [NCH-1:0]   in_ready,
  input  logic [NCH-1:0]   clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ch,
  output logic [1:0]       out_state,
  output logic             out_y,
  output logic [NCH-1:0]   busy
`ifdef FSM_SHARE_HITCNT_EN
  ,
  input  logic [CW-1:0]    hit_sel,
  input  logic             hit_clr,
  output logic [7:0]       hit_count
`endif
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t         ctx [NCH];
  logic [CW-1:0]  ptr;

  logic           stall;
  logic           grant;
  logic           gnt_found;
  logic [CW-1:0]  gnt_idx;
  logic [CW-1:0]  cand;
  logic [NCH-1:0] elig;
  logic [1:0]     gnt_ab;
  state_t         gnt_cur;
  state_t         gnt_nxt;

  function automatic state_t step(input state_t s, input logic a, input logic b);
    state_t n;
    n = S0;
    case (s)
      S0: n = (a ^ b) ? S1 : S0;
      S1: n = (a & b) ? S2 : S0;
      S2: n = (a | b) ? S3 : S0;
      S3: n = (a | b) ? S3 : S0;
      default: n = S0;
    endcase
    return n;
  endfunction

  // Round-robin search: first eligible channel at or after the pointer, with wrap.
  always_comb begin
    stall     = out_valid & ~out_ready;
    elig      = in_valid & ~clr;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = CW'((int'(ptr) + k) % NCH);
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    grant = gnt_found & ~stall & reset_n;
  end

  always_comb begin
    gnt_ab  = '0;
    gnt_cur = S0;
    for (int i = 0; i < NCH; i++) begin
      if (CW'(i) == gnt_idx) begin
        gnt_ab  = in_ab[2*i +: 2];
        gnt_cur = ctx[i];
      end
    end
    gnt_nxt = step(gnt_cur, gnt_ab[1], gnt_ab[0]);
  end

  always_comb begin
    in_ready = '0;
    busy     = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = grant && (gnt_idx == CW'(i));
      busy[i]     = (ctx[i] != S0);
    end
  end

  // Contexts, pointer and result register advance together; a stall freezes all of them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) ctx[i] <= S0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_state <= 2'b00;
      out_y     <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i])
          ctx[i] <= S0;
        else if (grant && (gnt_idx == CW'(i)))
          ctx[i] <= gnt_nxt;
      end
      if (grant) begin
        out_valid <= 1'b1;
        out_ch    <= gnt_idx;
        out_state <= gnt_nxt;
        out_y     <= (gnt_nxt == S1) || (gnt_nxt == S2);
        ptr       <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (!stall) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FSM_SHARE_HITCNT_EN
  logic [7:0] hit_cnt [NCH];

  // Counts S1->S2 advances per channel, saturating; a clear beats a same-cycle bump.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) hit_cnt[i] <= '0;
    end else if (hit_clr) begin
      for (int i = 0; i < NCH; i++) hit_cnt[i] <= '0;
    end else if (grant && gnt_cur == S1 && gnt_nxt == S2) begin
      for (int i = 0; i < NCH; i++) begin
        if (gnt_idx == CW'(i) && hit_cnt[i] != 8'hFF)
          hit_cnt[i] <= hit_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < NCH; i++) begin
      if (hit_sel == CW'(i)) hit_count = hit_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_fsm_share_sched.sv
// Self-checking bench for fsm_share_sched: directed steps plus random traffic
// compared against a transaction-level model of contexts, pointer and result.
module tb_fsm_share_sched;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NCH-1:0]   in_valid = '0;
  logic [2*NCH-1:0] in_ab = '0;
  logic [NCH-1:0]   in_ready;
  logic [NCH-1:0]   clr = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CW-1:0]    out_ch;
  logic [1:0]       out_state;
  logic             out_y;
  logic [NCH-1:0]   busy;
`ifdef FSM_SHARE_HITCNT_EN
  logic [CW-1:0]    hit_sel = '0;
  logic             hit_clr = 1'b0;
  logic [7:0]       hit_count;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int mctx [NCH];
  int mptr;
  bit mov;
  int mch;
  int mst;
  bit my;
  int mhit [NCH];

  fsm_share_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ab(in_ab), .in_ready(in_ready), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_state(out_state), .out_y(out_y), .busy(busy)
`ifdef FSM_SHARE_HITCNT_EN
    , .hit_sel(hit_sel), .hit_clr(hit_clr), .hit_count(hit_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic int refNext(input int s, input bit a, input bit b);
    case (s)
      0:       return (a != b) ? 1 : 0;
      1:       return (a && b) ? 2 : 0;
      default: return (a || b) ? 3 : 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      mctx[i] = 0;
      mhit[i] = 0;
    end
    mptr = 0; mov = 0; mch = 0; mst = 0; my = 0;
  endtask

  task automatic doReset();
    in_valid = '0; in_ab = '0; clr = '0; out_ready = 1'b1;
`ifdef FSM_SHARE_HITCNT_EN
    hit_clr = 1'b0;
`endif
    reset_n = 1'b0;
    @(posedge clk);
    #3;
    modelReset();
    reset_n = 1'b1;
    #1;
  endtask

  // One clock of stimulus: check grant before the edge, results after it.
  task automatic applyStimulus(input logic [3:0] v, input logic [7:0] ab, input logic [3:0] c,
                               input logic ordy, input string tag);
    int g;
    bit stall;
    int ns;
    logic [1:0] sym;
    logic [3:0] expRdy;
    logic [3:0] expBusy;
    bit hclr;
    in_valid = v; in_ab = ab; clr = c; out_ready = ordy;
    hclr = 1'b0;
`ifdef FSM_SHARE_HITCNT_EN
    hclr = hit_clr;
`endif
    stall = mov && !ordy;
    g = -1;
    if (!stall) begin
      for (int k = 0; k < NCH; k++) begin
        int idx;
        idx = (mptr + k) % NCH;
        if (g < 0 && v[2'(idx)] && !c[2'(idx)]) g = idx;
      end
    end
    expRdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    #1;
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(expRdy));
    @(posedge clk);
    for (int i = 0; i < NCH; i++) if (c[2'(i)]) mctx[i] = 0;
    if (hclr) begin
      for (int i = 0; i < NCH; i++) mhit[i] = 0;
    end
    if (g >= 0) begin
      sym = 2'(ab >> (2 * g));
      ns = refNext(mctx[g], sym[1], sym[0]);
      if (!hclr && mctx[g] == 1 && ns == 2 && mhit[g] < 255) mhit[g]++;
      mctx[g] = ns;
      mov = 1; mch = g; mst = ns; my = (ns == 1 || ns == 2);
      mptr = (g + 1) % NCH;
    end else if (!stall) begin
      mov = 0;
    end
    #1;
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(mov));
    if (mov) begin
      checkOutput({tag, ".out_ch"}, 32'(out_ch), 32'(mch));
      checkOutput({tag, ".out_state"}, 32'(out_state), 32'(mst));
      checkOutput({tag, ".out_y"}, 32'(out_y), 32'(my));
    end
    for (int i = 0; i < NCH; i++) expBusy[2'(i)] = (mctx[i] != 0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
`ifdef FSM_SHARE_HITCNT_EN
    checkOutput({tag, ".hit_count"}, 32'(hit_count), 32'(mhit[int'(hit_sel)]));
`endif
  endtask

  initial begin
    int expSt [5];
    int expY  [5];
    logic [7:0] seq0 [5];
    expSt = '{1, 2, 3, 3, 0};
    expY  = '{1, 1, 0, 0, 0};
    seq0  = '{8'b10, 8'b11, 8'b01, 8'b11, 8'b00};

    $display("[TB] start");
    doReset();
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.out_ch", 32'(out_ch), 32'd0);
    checkOutput("reset.out_state", 32'(out_state), 32'd0);
    checkOutput("reset.out_y", 32'(out_y), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd0);

    // Channel 0 walks S1,S2,S3,S3,S0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0001, seq0[i], 4'b0000, 1'b1, "ch0");
      checkOutput("ch0.const_state", 32'(out_state), 32'(expSt[i]));
      checkOutput("ch0.const_y", 32'(out_y), 32'(expY[i]));
      checkOutput("ch0.const_ch", 32'(out_ch), 32'd0);
    end

    // All channels valid: strict rotation from channel 0
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 8'h00, 4'b0000, 1'b1, "rr");
      checkOutput("rr.const_ch", 32'(out_ch), 32'(i % NCH));
    end

    // Channel 2 to S2, then stall with channels 1 and 2 pending
    doReset();
    applyStimulus(4'b0100, 8'b0010_0000, 4'b0000, 1'b1, "stall.s1");
    applyStimulus(4'b0100, 8'b0011_0000, 4'b0000, 1'b1, "stall.s2");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0110, 8'b0011_1100, 4'b0000, 1'b0, "stall.hold");
      checkOutput("stall.const_state", 32'(out_state), 32'd2);
      checkOutput("stall.const_busy2", 32'(busy[2]), 32'd1);
    end
    applyStimulus(4'b0110, 8'b0011_1100, 4'b0000, 1'b1, "stall.release");
    checkOutput("stall.const_ch", 32'(out_ch), 32'd1);

    // clr wins over a pending symbol
    doReset();
    applyStimulus(4'b0010, 8'b0000_1000, 4'b0000, 1'b1, "clr.s1");
    applyStimulus(4'b0010, 8'b0000_1100, 4'b0010, 1'b1, "clr.hit");
    checkOutput("clr.const_busy1", 32'(busy[1]), 32'd0);
    applyStimulus(4'b0010, 8'b0000_1100, 4'b0000, 1'b1, "clr.after");
    checkOutput("clr.const_state", 32'(out_state), 32'd0);

    // Random traffic
    doReset();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] rc;
      rc = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      applyStimulus(4'($urandom), 8'($urandom), rc, ($urandom_range(0, 3) != 0), "rand");
    end

    // Asynchronous reset in the middle of a clock period
    doReset();
    applyStimulus(4'b0001, 8'b0000_0010, 4'b0000, 1'b1, "areset.load");
    in_valid = 4'b1111;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("areset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("areset.busy", 32'(busy), 32'd0);
    checkOutput("areset.in_ready", 32'(in_ready), 32'd0);
    modelReset();
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    applyStimulus(4'b1111, 8'h00, 4'b0000, 1'b1, "areset.first");
    checkOutput("areset.const_ch", 32'(out_ch), 32'd0);

`ifdef FSM_SHARE_HITCNT_EN
    doReset();
    hit_sel = 2'd3;
    for (int n = 0; n < 300; n++) begin
      applyStimulus(4'b1000, 8'b1000_0000, 4'b0000, 1'b1, "hit.s1");
      applyStimulus(4'b1000, 8'b1100_0000, 4'b0000, 1'b1, "hit.s2");
      applyStimulus(4'b1000, 8'b0000_0000, 4'b0000, 1'b1, "hit.s0");
    end
    checkOutput("hit.const_sat", 32'(hit_count), 32'd255);
    applyStimulus(4'b1000, 8'b1000_0000, 4'b0000, 1'b1, "hit.pre");
    hit_clr = 1'b1;
    applyStimulus(4'b1000, 8'b1100_0000, 4'b0000, 1'b1, "hit.clr");
    hit_clr = 1'b0;
    checkOutput("hit.const_clr", 32'(hit_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
